wm_run_seq: RTL

Washing-program sequencer. It sits directly downstream of the control-panel block (wm_ctrl) and the ultrasonic distance block (wm_us_ctrl). It consumes the selected program (wash/rinse/dry enables, rinse repeat count, water level) and the measured water distance, then steps the machine through fill, agitate, drain and spin phases. It drives the valve and motor outputs, a remaining-seconds value for the FND mux, and a one-cycle done pulse for the buzzer.

---
 rtl/wm_run_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/wm_run_seq.sv
// Washing-program sequencer: steps the selected wash / rinse / dry blocks through
// fill, agitate, drain and spin phases on 1 s ticks, with pause, stop and fill-timeout error.
module wm_run_seq #(
   parameter int WASH_SEC         = 20,
   parameter int RINSE_SEC        = 10,
   parameter int DRAIN_SEC        = 5,
   parameter int DRY_SEC          = 15,
   parameter int FILL_TIMEOUT_SEC = 30,
   parameter int DIST_HIGH        = 5,
   parameter int DIST_MID         = 10,
   parameter int DIST_LOW         = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1sec,
   input  logic        start,
   input  logic        stop,
   input  logic        sel_wash,
   input  logic        sel_rinse,
   input  logic        sel_dry,
   input  logic [1:0]  rinse_rep,
   input  logic [1:0]  water_lvl,
   input  logic        us_dist_en,
   input  logic [7:0]  us_dist,
   output logic        valve_in,
   output logic        valve_out,
   output logic        motor_on,
   output logic        motor_fast,
   output logic [2:0]  phase,
   output logic [11:0] remain_sec,
   output logic        busy,
   output logic        paused,
   output logic        done,
   output logic        err
);

   // State codes double as the phase output encoding.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_DRAIN = 3'd4,
      S_DRY   = 3'd5,
      S_ERR   = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] cnt_q, cnt_d;
   logic [11:0] fill_q, fill_d;
   logic        sel_rinse_q, sel_rinse_d;
   logic        sel_dry_q, sel_dry_d;
   logic [1:0]  rep_q, rep_d;
   logic [1:0]  lvl_q, lvl_d;
   logic [1:0]  ridx_q, ridx_d;
   logic        blk_rinse_q, blk_rinse_d;
   logic        paused_q, paused_d;
   logic        done_q, done_d;
   logic        tick_en;
   logic        busy_w;
   logic        fill_hit;
   logic [7:0]  target;

   function automatic logic [11:0] dur(input state_t s);
      case (s)
         S_WASH:  dur = 12'(WASH_SEC);
         S_RINSE: dur = 12'(RINSE_SEC);
         S_DRAIN: dur = 12'(DRAIN_SEC);
         S_DRY:   dur = 12'(DRY_SEC);
         default: dur = 12'd0;
      endcase
   endfunction

   assign busy_w  = (state_q != S_IDLE) && (state_q != S_ERR);
   assign tick_en = tick_1sec & ~paused_q;

   always_comb begin
      case (lvl_q)
         2'd3:    target = 8'(DIST_HIGH);
         2'd2:    target = 8'(DIST_MID);
         default: target = 8'(DIST_LOW);
      endcase
   end

   // us_dist is a valid-only stream: sampled when us_dist_en is high, never back-pressured.
   assign fill_hit = us_dist_en & ~paused_q & (us_dist <= target);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 12'd0;
         fill_q      <= 12'd0;
         sel_rinse_q <= 1'b0;
         sel_dry_q   <= 1'b0;
         rep_q       <= 2'd0;
         lvl_q       <= 2'd0;
         ridx_q      <= 2'd0;
         blk_rinse_q <= 1'b0;
         paused_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_q      <= fill_d;
         sel_rinse_q <= sel_rinse_d;
         sel_dry_q   <= sel_dry_d;
         rep_q       <= rep_d;
         lvl_q       <= lvl_d;
         ridx_q      <= ridx_d;
         blk_rinse_q <= blk_rinse_d;
         paused_q    <= paused_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_d      = fill_q;
      sel_rinse_d = sel_rinse_q;
      sel_dry_d   = sel_dry_q;
      rep_d       = rep_q;
      lvl_d       = lvl_q;
      ridx_d      = ridx_q;
      blk_rinse_d = blk_rinse_q;
      paused_d    = paused_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !done_q && (sel_wash || sel_rinse || sel_dry)) begin
               sel_rinse_d = sel_rinse;
               sel_dry_d   = sel_dry;
               rep_d       = (rinse_rep == 2'd0) ? 2'd1 : rinse_rep;
               lvl_d       = water_lvl;
               ridx_d      = 2'd0;
               blk_rinse_d = !sel_wash;
               state_d     = (sel_wash || sel_rinse) ? S_FILL : S_DRY;
            end
         end
         S_FILL: begin
            if (fill_hit) begin
               state_d = blk_rinse_q ? S_RINSE : S_WASH;
            end else if (tick_en) begin
               if (fill_q == 12'(FILL_TIMEOUT_SEC - 1)) state_d = S_ERR;
               else fill_d = fill_q + 12'd1;
            end
         end
         S_WASH, S_RINSE: begin
            if (tick_en) begin
               if (cnt_q == 12'd1) state_d = S_DRAIN;
               else cnt_d = cnt_q - 12'd1;
            end
         end
         S_DRAIN: begin
            if (tick_en) begin
               if (cnt_q == 12'd1) begin
                  // End of a wash or rinse block: pick the next block or finish.
                  if (!blk_rinse_q && sel_rinse_q) begin
                     state_d     = S_FILL;
                     blk_rinse_d = 1'b1;
                     ridx_d      = 2'd0;
                  end else if (blk_rinse_q && (({1'b0, ridx_q} + 3'd1) < {1'b0, rep_q})) begin
                     state_d = S_FILL;
                     ridx_d  = ridx_q + 2'd1;
                  end else if (sel_dry_q) begin
                     state_d = S_DRY;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 12'd1;
               end
            end
         end
         S_DRY: begin
            if (tick_en) begin
               if (cnt_q == 12'd1) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 12'd1;
               end
            end
         end
         default: ;
      endcase
      if (start && busy_w) paused_d = ~paused_q;
      if (stop) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
      if (state_d == S_IDLE || state_d == S_ERR) paused_d = 1'b0;
      if (state_d != state_q) begin
         cnt_d  = dur(state_d);
         fill_d = 12'd0;
      end
   end

   always_comb begin
      valve_in   = 1'b0;
      valve_out  = 1'b0;
      motor_on   = 1'b0;
      motor_fast = 1'b0;
      err        = 1'b0;
      case (state_q)
         S_FILL:          valve_in = ~paused_q;
         S_WASH, S_RINSE: motor_on = ~paused_q;
         S_DRAIN:         valve_out = 1'b1;
         S_DRY: begin
            valve_out  = 1'b1;
            motor_on   = ~paused_q;
            motor_fast = ~paused_q;
         end
         S_ERR:           err = 1'b1;
         default: ;
      endcase
   end

   assign phase      = state_q;
   assign remain_sec = cnt_q;
   assign busy       = busy_w;
   assign paused     = paused_q;
   assign done       = done_q;

endmodule
